if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the PC, issues single-outstanding requests to instruction memory, and registers fetched instructions into the IF/ID pipeline register that feeds the decoder and ID_EX. It absorbs stalls from the hazard unit, variable memory latency and PC redirects resolved in EX (taken branch, j/jal/jr), presenting at most one valid instruction per cycle downstream.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset; must be word-aligned.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit: hold IF/ID contents and PC.
- RedirectValid  in  1  EX resolved a taken branch/jump this cycle.
- RedirectPc  in  32  target PC; bits [1:0] ignored (treated as 00).
- ImemAddr  out  32  word-aligned fetch address, stable while ImemReq is high.
- ImemReq  out  1  request outstanding.
- ImemRdata  in  32  instruction; valid only in a cycle with ImemReady=1.
- ImemReady  in  1  completes the outstanding request this cycle.
- IfIdPc  out  32  PC+4 of the registered instruction.
- IfIdInstr  out  32  registered instruction; 0 (nop) when invalid.
- IfIdValid  out  1  IfIdInstr is a real instruction.

## Operation
- States: FETCH (request outstanding), HOLD (instruction returned during Stall, held in buffer, no request), DROP (redirect arrived mid-request; returning data discarded).
- ImemReq = !rst && (state==FETCH || state==DROP); ImemAddr = Pc. Completion = ImemReq && ImemReady.
- Reset: Pc=RESET_PC, state=FETCH, buffer empty, IfIdPc=0, IfIdInstr=0, IfIdValid=0.
- Priority each cycle: rst > RedirectValid > Stall > normal.
- Redirect: IfIdValid<=0, IfIdInstr<=0 regardless of Stall. FETCH+completion: data dropped, Pc<=target, stay FETCH. FETCH without completion: save target, go DROP. HOLD: discard buffer, Pc<=target, go FETCH. DROP: overwrite saved target.
- DROP + completion: data dropped, Pc<=saved target, go FETCH (a redirect in that same cycle uses the new target).
- FETCH + completion, no Stall: IfIdInstr<=ImemRdata, IfIdPc<=Pc+4, IfIdValid<=1, Pc<=Pc+4, stay FETCH.
- FETCH + completion + Stall: IF/ID unchanged; buffer<=(ImemRdata, Pc+4); Pc<=Pc+4; go HOLD.
- HOLD, Stall deasserted: IF/ID<=buffer, IfIdValid<=1, go FETCH. HOLD with Stall: all held.
- No Stall and no instruction delivered: IfIdValid<=0, IfIdInstr<=0 (bubble). Stall with no delivery: IF/ID held.
- Pc+4 wraps modulo 2^32; no exception.

## Timing
- Zero-wait memory (ImemReady high same cycle as request): one instruction per cycle; IfIdValid rises the cycle after rst falls +1.
- Fetch-to-IF/ID latency: 1 cycle after completion (registered).
- Redirect penalty: instruction at target appears in IF/ID earliest 1 cycle after its completion; at least one bubble after redirect.
- ImemAddr never changes while a request is outstanding (DROP preserves it).
- Reset asserted mid-request: request abandoned; memory must tolerate ImemReq dropping without ImemReady.

## Structure
- Shared pipeline package: state enum (FETCH/HOLD/DROP), RESET_PC default, NOP=32'h0.
- One sub-module: if_buf, single-entry instruction/PC hold buffer with load, drain and clear.
- PC register, next-PC selection and IF/ID register live in the top.

## Test plan
- Reset, zero-wait memory returning Addr as data -> ImemAddr 3000,3004,3008…; IfIdPc 3004,3008…; IfIdValid 1 from 2nd cycle after reset.
- Stall for 3 cycles with completion in first -> IF/ID frozen, state HOLD, ImemReq 0; Stall drop -> buffered instr (Pc+4 correct) appears next cycle, no loss or duplicate.
- Memory latency 3, redirect to 32'h0000_3100 in 2nd wait cycle -> ImemAddr stable until ready, data discarded, next ImemAddr 3100, IfIdValid 0 throughout.
- RedirectValid and Stall together in FETCH with completion -> IfIdValid 0, next ImemAddr = target.
- Redirect to 32'h0000_3103 -> ImemAddr 3100.
- Pc=32'hFFFF_FFFC fetched -> IfIdPc 0, next ImemAddr 0; rst asserted during outstanding request -> next cycle ImemReq 0, outputs zero.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset PC default, nop encoding.
// Imported by if_stage and if_buf; no logic of its own.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_buf.sv
// Single-entry instruction/PC hold buffer; load captures on the clock edge, contents visible next cycle.
// Clear wins over load, load wins over drain; no backpressure, caller guarantees it is empty before loading.
module if_buf
  import if_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_load_instr,
  input  logic [31:0] i_load_pc,
  input  logic        i_drain,
  input  logic        i_clear,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP;
      r_pc    <= 32'h0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_load_instr;
      r_pc    <= i_load_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
      r_instr <= NOP;
      r_pc    <= 32'h0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch: PC, single-outstanding imem request, IF/ID register (1 cycle after completion).
// Stall freezes IF/ID and PC, parking one returned instruction in if_buf; EX redirects squash IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_instr,
  output logic        o_if_id_valid
);

  localparam logic [31:0] RESET_PC_AL = word_align(RESET_PC);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_drop_pc;
  logic [31:0]  r_ifid_pc;
  logic [31:0]  r_ifid_instr;
  logic         r_ifid_valid;

  fetch_state_t w_state_nxt;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_drop_pc_nxt;
  logic [31:0]  w_ifid_pc_nxt;
  logic [31:0]  w_ifid_instr_nxt;
  logic         w_ifid_valid_nxt;
  logic         w_req;
  logic         w_cpl;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_redirect_tgt;
  logic         w_buf_load;
  logic         w_buf_drain;
  logic         w_buf_clear;
  logic         w_buf_valid;
  logic [31:0]  w_buf_instr;
  logic [31:0]  w_buf_pc;

  assign w_req          = !i_rst && (r_state == ST_FETCH || r_state == ST_DROP);
  assign w_cpl          = w_req && i_imem_ready;
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_redirect_tgt = word_align(i_redirect_pc);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_pc_nxt    = r_drop_pc;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_valid_nxt = r_ifid_valid;
    w_buf_load       = 1'b0;
    w_buf_drain      = 1'b0;
    w_buf_clear      = 1'b0;

    if (i_redirect_valid) begin
      // Squash IF/ID even under Stall: the instruction there is on the wrong path.
      w_ifid_instr_nxt = NOP;
      w_ifid_valid_nxt = 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (w_cpl) begin
            w_pc_nxt = w_redirect_tgt;
          end else begin
            w_drop_pc_nxt = w_redirect_tgt;
            w_state_nxt   = ST_DROP;
          end
        end
        ST_HOLD: begin
          w_buf_clear = 1'b1;
          w_pc_nxt    = w_redirect_tgt;
          w_state_nxt = ST_FETCH;
        end
        ST_DROP: begin
          if (w_cpl) begin
            w_pc_nxt    = w_redirect_tgt;
            w_state_nxt = ST_FETCH;
          end else begin
            w_drop_pc_nxt = w_redirect_tgt;
          end
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end else if (r_state == ST_DROP) begin
      // ImemAddr must not move until the abandoned request completes.
      if (w_cpl) begin
        w_pc_nxt    = r_drop_pc;
        w_state_nxt = ST_FETCH;
      end
      if (!i_stall) begin
        w_ifid_instr_nxt = NOP;
        w_ifid_valid_nxt = 1'b0;
      end
    end else if (i_stall) begin
      if (r_state == ST_FETCH && w_cpl) begin
        w_buf_load  = 1'b1;
        w_pc_nxt    = w_pc_plus4;
        w_state_nxt = ST_HOLD;
      end
    end else begin
      if (r_state == ST_HOLD) begin
        w_ifid_instr_nxt = w_buf_instr;
        w_ifid_pc_nxt    = w_buf_pc;
        w_ifid_valid_nxt = w_buf_valid;
        w_buf_drain      = 1'b1;
        w_state_nxt      = ST_FETCH;
      end else if (w_cpl) begin
        w_ifid_instr_nxt = i_imem_rdata;
        w_ifid_pc_nxt    = w_pc_plus4;
        w_ifid_valid_nxt = 1'b1;
        w_pc_nxt         = w_pc_plus4;
      end else begin
        w_ifid_instr_nxt = NOP;
        w_ifid_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC_AL;
      r_drop_pc    <= 32'h0;
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= NOP;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop_pc    <= w_drop_pc_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  if_buf u_if_buf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_buf_load),
    .i_load_instr (i_imem_rdata),
    .i_load_pc    (w_pc_plus4),
    .i_drain      (w_buf_drain),
    .i_clear      (w_buf_clear),
    .o_valid      (w_buf_valid),
    .o_instr      (w_buf_instr),
    .o_pc         (w_buf_pc)
  );

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_if_id_pc    = r_ifid_pc;
  assign o_if_id_instr = r_ifid_instr;
  assign o_if_id_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns its fetch address as the instruction word.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_addr      (imem_addr),
    .o_imem_req       (imem_req),
    .i_imem_rdata     (imem_rdata),
    .i_imem_ready     (imem_ready),
    .o_if_id_pc       (if_id_pc),
    .o_if_id_instr    (if_id_instr),
    .o_if_id_valid    (if_id_valid)
  );

  assign imem_rdata = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp 00000000", if_id_pc); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_ifid_instr got %h exp 00000000", if_id_instr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_ifid_valid got %b exp 0", if_id_valid); end
    checks++; if (imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL reset_addr got %h exp 00003000", imem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL first_valid got %b exp 0", if_id_valid); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_addr;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_addr = 32'h0000_3000 + 32'(4 * k);
      checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL zw_addr[%0d] got %h exp %h", k, imem_addr, exp_addr); end
      checks++; if (if_id_pc !== exp_addr) begin errors++; $display("FAIL zw_ifid_pc[%0d] got %h exp %h", k, if_id_pc, exp_addr); end
      checks++; if (if_id_instr !== exp_addr - 32'd4) begin errors++; $display("FAIL zw_ifid_instr[%0d] got %h exp %h", k, if_id_instr, exp_addr - 32'd4); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL zw_ifid_valid[%0d] got %b exp 1", k, if_id_valid); end
    end
  endtask

  task automatic test_stall();
    // Fetch of 3010 completes in the first stalled cycle and must be parked.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", k, imem_req); end
      checks++; if (if_id_pc !== 32'h0000_3010) begin errors++; $display("FAIL stall_ifid_pc[%0d] got %h exp 00003010", k, if_id_pc); end
      checks++; if (if_id_instr !== 32'h0000_300C) begin errors++; $display("FAIL stall_ifid_instr[%0d] got %h exp 0000300c", k, if_id_instr); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid_valid[%0d] got %b exp 1", k, if_id_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_pc !== 32'h0000_3014) begin errors++; $display("FAIL unstall_ifid_pc got %h exp 00003014", if_id_pc); end
    checks++; if (if_id_instr !== 32'h0000_3010) begin errors++; $display("FAIL unstall_ifid_instr got %h exp 00003010", if_id_instr); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL unstall_ifid_valid got %b exp 1", if_id_valid); end
    checks++; if (imem_addr !== 32'h0000_3014 || imem_req !== 1'b1) begin errors++; $display("FAIL unstall_fetch got addr %h req %b exp 00003014 1", imem_addr, imem_req); end
    tick();
    checks++; if (if_id_instr !== 32'h0000_3014 || if_id_pc !== 32'h0000_3018) begin errors++; $display("FAIL after_stall got instr %h pc %h exp 00003014 00003018", if_id_instr, if_id_pc); end
  endtask

  task automatic test_latency_redirect();
    imem_ready = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h0000_3018) begin errors++; $display("FAIL lat_addr1 got %h exp 00003018", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL lat_bubble1 got valid %b instr %h exp 0 00000000", if_id_valid, if_id_instr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h0000_3018 || imem_req !== 1'b1) begin errors++; $display("FAIL lat_addr2 got addr %h req %b exp 00003018 1", imem_addr, imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL lat_bubble2 got %b exp 0", if_id_valid); end
    imem_ready = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h0000_3100) begin errors++; $display("FAIL lat_target_addr got %h exp 00003100", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL lat_dropped got valid %b instr %h exp 0 00000000", if_id_valid, if_id_instr); end
    tick();
    checks++; if (if_id_instr !== 32'h0000_3100 || if_id_pc !== 32'h0000_3104 || if_id_valid !== 1'b1) begin errors++; $display("FAIL lat_target_ifid got instr %h pc %h valid %b exp 00003100 00003104 1", if_id_instr, if_id_pc, if_id_valid); end
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3200; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL rs_squash got valid %b instr %h exp 0 00000000", if_id_valid, if_id_instr); end
    checks++; if (imem_addr !== 32'h0000_3200 || imem_req !== 1'b1) begin errors++; $display("FAIL rs_addr got addr %h req %b exp 00003200 1", imem_addr, imem_req); end
    tick();
    checks++; if (if_id_instr !== 32'h0000_3200 || if_id_pc !== 32'h0000_3204) begin errors++; $display("FAIL rs_target_ifid got instr %h pc %h exp 00003200 00003204", if_id_instr, if_id_pc); end
  endtask

  task automatic test_unaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3103;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h0000_3100) begin errors++; $display("FAIL unal_addr got %h exp 00003100", imem_addr); end
    tick();
    checks++; if (if_id_pc !== 32'h0000_3104 || if_id_instr !== 32'h0000_3100) begin errors++; $display("FAIL unal_ifid got pc %h instr %h exp 00003104 00003100", if_id_pc, if_id_instr); end
  endtask

  task automatic test_hold_redirect();
    // Parked instruction at 3104 must be discarded by a redirect while still stalled.
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hr_hold_req got %b exp 0", imem_req); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3300;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h0000_3300 || imem_req !== 1'b1) begin errors++; $display("FAIL hr_addr got addr %h req %b exp 00003300 1", imem_addr, imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL hr_squash got %b exp 0", if_id_valid); end
    stall = 1'b0;
    tick();
    checks++; if (if_id_instr !== 32'h0000_3300 || if_id_pc !== 32'h0000_3304 || if_id_valid !== 1'b1) begin errors++; $display("FAIL hr_target got instr %h pc %h valid %b exp 00003300 00003304 1", if_id_instr, if_id_pc, if_id_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch_addr got %h exp fffffffc", imem_addr); end
    tick();
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL wrap_ifid_pc got %h exp 00000000", if_id_pc); end
    checks++; if (if_id_instr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ifid_instr got %h exp fffffffc", if_id_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 00000000", imem_addr); end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req_comb got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %b exp 0", imem_req); end
    checks++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL rm_ifid got pc %h instr %h valid %b exp 0 0 0", if_id_pc, if_id_instr, if_id_valid); end
    checks++; if (imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL rm_addr got %h exp 00003000", imem_addr); end
    rst = 1'b0; imem_ready = 1'b1;
    tick();
    checks++; if (if_id_instr !== 32'h0000_3000 || if_id_pc !== 32'h0000_3004 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rm_restart got instr %h pc %h valid %b exp 00003000 00003004 1", if_id_instr, if_id_pc, if_id_valid); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    test_reset();
    test_zero_wait();
    test_stall();
    test_latency_redirect();
    test_redirect_stall();
    test_unaligned();
    test_hold_redirect();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
